lfsr_req_scheduler: RTL and testbench

//  Shares one 5-bit Fibonacci LFSR (x^5+x^3+1, period 31) between N_REQ requesters.

---
 rtl/lfsr_req_scheduler_if.sv | 24 ++
 rtl/lfsr_req_scheduler.sv | 157 +++++++++++++++
 tb/tb_lfsr_req_scheduler.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_req_scheduler_if.sv
// Request/grant bundle between random-number consumers and the LFSR scheduler.
// Latency: n/a (wires only).
// Backpressure: consumers hold req until they ack or drop it; the scheduler holds gnt meanwhile.
interface lfsr_req_scheduler_if #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] ack;
   logic [N_REQ-1:0] gnt;
   logic             rnd_valid;
   logic [4:0]       rnd_data;

   // Consumer side
   modport master (
      output req, ack,
      input  gnt, rnd_valid, rnd_data
   );

   // Scheduler side
   modport slave (
      input  req, ack,
      output gnt, rnd_valid, rnd_data
   );
endinterface

// File: rtl/lfsr_req_scheduler.sv
// Round-robin sharing of one 5-bit Fibonacci LFSR (x^5+x^3+1) among N_REQ requesters.
// Latency: req seen in IDLE at edge t -> gnt/rnd_data registered after edge t+1; ack steps LFSR next edge.
// Backpressure: grant held until ack, req drop, seed_load or rst (or watchdog when LFSR_SCHED_TIMEOUT_EN is defined).
module lfsr_req_scheduler #(
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 15
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                seed_load_i,
   input  logic [4:0]          seed_i,
   lfsr_req_scheduler_if.slave bus,
   output logic [4:0]          lfsr_q_o,
   output logic                timeout_o
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARB   = 2'd1,
      GRANT = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [4:0]       lfsr_q, lfsr_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [4:0]       rnd_data_q, rnd_data_d;
   logic [PW-1:0]    ptr_q, ptr_d;

   logic             win_vld;
   logic [PW-1:0]    win_idx;
   logic [PW-1:0]    cand;

`ifdef LFSR_SCHED_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             timeout_q, timeout_d;
`else
   // TIMEOUT only matters when the watchdog is built in.
   logic             unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT;
`endif

   // Round-robin search: first set req bit starting just after the last winner.
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      cand    = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = PW'((int'(ptr_q) + k) % N_REQ);
         if (!win_vld && bus.req[cand]) begin
            win_vld = 1'b1;
            win_idx = cand;
         end
      end
   end

   // Next-state: seed load overrides everything; otherwise IDLE -> ARB -> GRANT -> IDLE.
   always_comb begin
      state_d    = state_q;
      lfsr_d     = lfsr_q;
      gnt_d      = gnt_q;
      rnd_data_d = rnd_data_q;
      ptr_d      = ptr_q;
`ifdef LFSR_SCHED_TIMEOUT_EN
      cnt_d      = cnt_q;
      timeout_d  = 1'b0;
`endif
      if (seed_load_i) begin
         // All-zero would lock the LFSR, so it is replaced by 1.
         lfsr_d  = (seed_i == 5'd0) ? 5'd1 : seed_i;
         gnt_d   = '0;
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (|bus.req) state_d = ARB;
            end
            ARB: begin
               if (win_vld) begin
                  gnt_d      = N_REQ'(1) << win_idx;
                  rnd_data_d = lfsr_q;
                  ptr_d      = win_idx;
                  state_d    = GRANT;
`ifdef LFSR_SCHED_TIMEOUT_EN
                  cnt_d      = '0;
`endif
               end else begin
                  state_d = IDLE;
               end
            end
            GRANT: begin
               if (|(bus.ack & gnt_q)) begin
                  // Accepted: consume this value so nobody else sees it.
                  lfsr_d  = {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[2]};
                  gnt_d   = '0;
                  state_d = IDLE;
               end else if (!(|(bus.req & gnt_q))) begin
                  // Grantee walked away: value stays for the next grant.
                  gnt_d   = '0;
                  state_d = IDLE;
               end
`ifdef LFSR_SCHED_TIMEOUT_EN
               else if (cnt_q == CW'(TIMEOUT - 1)) begin
                  gnt_d     = '0;
                  timeout_d = 1'b1;
                  state_d   = IDLE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
`endif
            end
            default: begin
               gnt_d   = '0;
               state_d = IDLE;
            end
         endcase
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         lfsr_q     <= 5'd1;
         gnt_q      <= '0;
         rnd_data_q <= '0;
         ptr_q      <= PW'(N_REQ - 1);
`ifdef LFSR_SCHED_TIMEOUT_EN
         cnt_q      <= '0;
         timeout_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         lfsr_q     <= lfsr_d;
         gnt_q      <= gnt_d;
         rnd_data_q <= rnd_data_d;
         ptr_q      <= ptr_d;
`ifdef LFSR_SCHED_TIMEOUT_EN
         cnt_q      <= cnt_d;
         timeout_q  <= timeout_d;
`endif
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.rnd_valid = |gnt_q;
   assign bus.rnd_data  = rnd_data_q;
   assign lfsr_q_o      = lfsr_q;
`ifdef LFSR_SCHED_TIMEOUT_EN
   assign timeout_o     = timeout_q;
`else
   assign timeout_o     = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_req_scheduler.sv
// Directed and randomized checks of lfsr_req_scheduler against a behavioural model.
// Latency: model expects gnt two edges after req from IDLE, LFSR step one edge after ack.
// Backpressure: bench holds req until it acks or drops it.
module tb_lfsr_req_scheduler;

   logic       clk = 1'b0;
   logic       rst;
   logic       seed_load;
   logic [4:0] seed;
   logic [4:0] lfsr_q;
   logic       timeout;

   lfsr_req_scheduler_if #(.N_REQ(4)) bus ();

   lfsr_req_scheduler #(.N_REQ(4), .TIMEOUT(15)) dut (
      .clk         (clk),
      .rst         (rst),
      .seed_load_i (seed_load),
      .seed_i      (seed),
      .bus         (bus),
      .lfsr_q_o    (lfsr_q),
      .timeout_o   (timeout)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model state
   int lfsr_m;
   int ptr_m;

   function automatic int lfsr_step(input int v);
      int b4, b2;
      b4 = (v >> 4) & 1;
      b2 = (v >> 2) & 1;
      return ((v << 1) & 30) | (b4 ^ b2);
   endfunction

   function automatic int rr_pick(input logic [3:0] r, input int p);
      for (int k = 1; k <= 4; k++)
         if (r[(p + k) % 4]) return (p + k) % 4;
      return -1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; seed_load = 1'b0; seed = '0;
      bus.req = '0; bus.ack = '0;
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      lfsr_m = 1;
      ptr_m  = 3;
   endtask

   // Raise req pattern r from IDLE and check the resulting grant.
   task automatic get_grant(input logic [3:0] r, output int w);
      int n;
      bus.req = r; bus.ack = '0;
      n = 0;
      while (bus.gnt == '0 && n < 10) begin
         @(negedge clk);
         n++;
      end
      w = rr_pick(r, ptr_m);
      chk("grant_latency", n, 2);
      chk("gnt_onehot", {28'd0, bus.gnt}, 32'd1 << w);
      chk("rnd_valid", {31'd0, bus.rnd_valid}, 1);
      chk("rnd_data", {27'd0, bus.rnd_data}, lfsr_m);
      chk("timeout_idle", {31'd0, timeout}, 0);
      ptr_m = w;
   endtask

   task automatic ack_grant(input int w, input bit drop);
      bus.ack = 4'(1 << w);
      if (drop) bus.req[w] = 1'b0;
      @(negedge clk);
      bus.ack = '0;
      lfsr_m = lfsr_step(lfsr_m);
      chk("gnt_after_ack", {28'd0, bus.gnt}, 0);
      chk("lfsr_after_ack", {27'd0, lfsr_q}, lfsr_m);
   endtask

   task automatic drop_grant(input int w);
      bus.req[w] = 1'b0;
      @(negedge clk);
      chk("gnt_after_drop", {28'd0, bus.gnt}, 0);
      chk("lfsr_after_drop", {27'd0, lfsr_q}, lfsr_m);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int w, a;
      logic [4:0] exp5 [5];
      logic [3:0] r;
      exp5[0] = 5'b00001; exp5[1] = 5'b00010; exp5[2] = 5'b00100;
      exp5[3] = 5'b01001; exp5[4] = 5'b10010;

      // Reset state
      do_reset();
      chk("rst_gnt", {28'd0, bus.gnt}, 0);
      chk("rst_valid", {31'd0, bus.rnd_valid}, 0);
      chk("rst_data", {27'd0, bus.rnd_data}, 0);
      chk("rst_lfsr", {27'd0, lfsr_q}, 1);
      chk("rst_timeout", {31'd0, timeout}, 0);

      // Single requester walks the full LFSR period
      for (int i = 0; i < 31; i++) begin
         get_grant(4'b0001, w);
         if (i < 5) chk("t1_seq", {27'd0, bus.rnd_data}, {27'd0, exp5[i]});
         ack_grant(w, 1'b0);
      end
      chk("t1_period", {27'd0, lfsr_q}, 1);

      // Reset mid-grant aborts without stepping
      get_grant(4'b0001, w);
      do_reset();
      chk("rst_mid_gnt", {28'd0, bus.gnt}, 0);
      chk("rst_mid_lfsr", {27'd0, lfsr_q}, 1);

      // All four requesting: strict rotation
      for (int i = 0; i < 5; i++) begin
         get_grant(4'b1111, w);
         chk("t2_gnt", {28'd0, bus.gnt}, 32'd1 << (i % 4));
         chk("t2_seq", {27'd0, bus.rnd_data}, {27'd0, exp5[i]});
         ack_grant(w, 1'b0);
      end
      bus.req = '0;
      @(negedge clk);

      // Seeding, including the all-zero replacement
      seed_load = 1'b1; seed = 5'b00000;
      @(negedge clk);
      chk("t3_seed_zero", {27'd0, lfsr_q}, 1);
      seed = 5'b10101;
      @(negedge clk);
      seed_load = 1'b0;
      lfsr_m = 5'b10101;
      get_grant(4'b0010, w);
      chk("t3_seed_data", {27'd0, bus.rnd_data}, 5'b10101);
      ack_grant(w, 1'b0);
      chk("t3_after_ack", {27'd0, lfsr_q}, 5'b01010);

      // Withdrawn request repeats the value
      get_grant(4'b0100, w);
      drop_grant(w);
      get_grant(4'b0100, w);
      ack_grant(w, 1'b0);

      // Seed load during GRANT clears the grant on the same edge
      get_grant(4'b1000, w);
      seed_load = 1'b1; seed = 5'b00111;
      @(negedge clk);
      seed_load = 1'b0;
      lfsr_m = 5'b00111;
      chk("t5_gnt", {28'd0, bus.gnt}, 0);
      chk("t5_valid", {31'd0, bus.rnd_valid}, 0);
      chk("t5_lfsr", {27'd0, lfsr_q}, 5'b00111);
      get_grant(4'b1000, w);
      ack_grant(w, 1'b0);

      // Randomized traffic
      for (int i = 0; i < 60; i++) begin
         r = 4'($urandom_range(1, 15));
         get_grant(r, w);
         a = $urandom_range(0, 3);
         case (a)
            0: ack_grant(w, 1'b0);
            1: ack_grant(w, 1'b1);
            2: drop_grant(w);
            default: begin
               bus.ack = ~(4'(1 << w));
               @(negedge clk);
               bus.ack = '0;
               chk("spurious_ack_gnt", {28'd0, bus.gnt}, 32'd1 << w);
               chk("spurious_ack_lfsr", {27'd0, lfsr_q}, lfsr_m);
               ack_grant(w, 1'b0);
            end
         endcase
      end

`ifdef LFSR_SCHED_TIMEOUT_EN
      // Watchdog revokes an un-acked grant after TIMEOUT cycles
      begin
         int cyc;
         get_grant(4'b0001, w);
         cyc = 1;
         while (bus.gnt != '0 && cyc < 40) begin
            @(negedge clk);
            if (bus.gnt != '0) cyc++;
         end
         chk("t6_cycles", cyc, 15);
         chk("t6_gnt", {28'd0, bus.gnt}, 0);
         chk("t6_pulse", {31'd0, timeout}, 1);
         chk("t6_lfsr", {27'd0, lfsr_q}, lfsr_m);
         bus.req = '0;
         @(negedge clk);
         chk("t6_pulse_end", {31'd0, timeout}, 0);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
